// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
// Slice geometry and configuration checks live here so every file agrees.
package adder_pkg;

    localparam int DEF_W      = 32;
    localparam int DEF_STAGES = 4;

    typedef struct packed {
        logic carry;
        logic msb_cin;
    } ctl_t;

    function automatic bit cfg_ok(int w, int s);
        return (s >= 1) && (w >= s) && ((w % s) == 0);
    endfunction

    localparam bit DEF_OK = cfg_ok(DEF_W, DEF_STAGES);

    function automatic int slice_lo(int k, int c);
        return k * c;
    endfunction

    function automatic int slice_hi(int k, int c);
        return k * c + c - 1;
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand and result handshakes of the pipelined add/subtract unit.
interface pipelined_adder_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );

endinterface

// File: rtl/adder_slice.sv
// One C-bit carry-propagating slice: {co, s} = a + b + ci.
module adder_slice #(
    parameter int C = 8
) (
    input  logic [C-1:0] a,
    input  logic [C-1:0] b,
    input  logic         ci,
    output logic [C-1:0] s,
    output logic         co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{C{1'b0}}, ci};

endmodule

// File: rtl/pipelined_adder.sv
// W-bit add/subtract split into STAGES slices, one slice per stage,
// with valid/ready on both sides and a single global advance enable.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int W      = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    pipelined_adder_if.slave bus
);

    localparam int C = W / STAGES;
    localparam int L = STAGES - 1;

    typedef struct packed {
        logic [W-1:0] acc;
        logic [W-1:0] braw;
        ctl_t         ctl;
    } stage_t;

    if (!cfg_ok(W, STAGES)) begin : g_bad_cfg
        $error("pipelined_adder: STAGES must divide W");
    end

    logic         en;
    logic [W-1:0] b_eff;
    logic         c0;

    assign en           = !g_st[L].v_q || bus.out_ready;
    assign bus.in_ready = en;
    assign b_eff        = bus.sub ? ~bus.b : bus.b;
    assign c0           = bus.sub ? 1'b1 : bus.cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = slice_lo(k, C);
        localparam int HI = slice_hi(k, C);

        logic [W-1:0] acc_in;
        logic [W-1:0] b_in;
        logic         ci;
        logic         v_in;
        logic [C-1:0] sa;
        logic [C-1:0] sb;
        logic [C-1:0] ss;
        logic         co;
        stage_t       nx;
        stage_t       q;
        logic         v_q;
        logic         unused_q;

        if (k == 0) begin : g_head
            assign acc_in = bus.a;
            assign b_in   = b_eff;
            assign ci     = c0;
            assign v_in   = bus.in_valid;
        end else begin : g_body
            assign acc_in = g_st[k-1].q.acc;
            assign b_in   = g_st[k-1].q.braw;
            assign ci     = g_st[k-1].q.ctl.carry;
            assign v_in   = g_st[k-1].v_q;
        end

        assign sa = acc_in[HI:LO];
        assign sb = b_in[HI:LO];

        adder_slice #(
            .C(C)
        ) u_slice (
            .a (sa),
            .b (sb),
            .ci(ci),
            .s (ss),
            .co(co)
        );

        // Carry into this slice's top bit; only the last stage's copy matters.
        always_comb begin
            nx             = '0;
            nx.acc         = acc_in;
            nx.acc[HI:LO]  = ss;
            nx.braw        = b_in;
            nx.ctl.carry   = co;
            nx.ctl.msb_cin = sa[C-1] ^ sb[C-1] ^ ss[C-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                q   <= '0;
            end else if (en) begin
                v_q <= v_in;
                q   <= nx;
            end
        end

        assign unused_q = ^{q.braw, q.ctl.msb_cin};
    end

    assign bus.out_valid = g_st[L].v_q;
    assign bus.sum       = g_st[L].q.acc;
    assign bus.carry_out = g_st[L].q.ctl.carry;
    assign bus.overflow  = g_st[L].q.ctl.carry ^ g_st[L].q.ctl.msb_cin;

endmodule
